counter_updown_mod: RTL and testbench



---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_updown_mod.sv | 106 ++++++++++
 tb/tb_counter_updown_mod.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types for the up/down modulo counter: end-of-range modes and FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2
  } cnt_mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with programmable modulus, load and
// wrap / saturate / one-shot end-of-range behaviour.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned     N         = 32,
  parameter logic [N-1:0]    RESET_VAL = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] max_val,
  input  logic [1:0]   mode,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         wrap,
  output logic         done
);

  logic [N-1:0] q_r;
  logic         wrap_r;
  logic         done_r;
  cnt_state_e   state_r;

  logic [N-1:0] q_nxt_s;
  logic         wrap_nxt_s;
  logic         done_nxt_s;
  cnt_state_e   state_nxt_s;
  logic         at_bound_s;
  cnt_mode_e    mode_s;

  // Next-state, boundary detection and end-of-range handling.
  always_comb begin
    mode_s      = cnt_mode_e'(mode);
    q_nxt_s     = q_r;
    wrap_nxt_s  = 1'b0;
    done_nxt_s  = done_r;
    state_nxt_s = state_r;

    // A loaded value above max_val is deliberately treated as "at boundary".
    if (up) begin
      at_bound_s = (q_r >= max_val);
    end else begin
      at_bound_s = (q_r == {N{1'b0}});
    end

    if (load) begin
      q_nxt_s     = load_val;
      done_nxt_s  = 1'b0;
      state_nxt_s = ST_RUN;
    end else if ((state_r == ST_RUN) && en) begin
      if (!at_bound_s) begin
        if (up) begin
          q_nxt_s = q_r + {{(N-1){1'b0}}, 1'b1};
        end else begin
          q_nxt_s = q_r - {{(N-1){1'b0}}, 1'b1};
        end
      end else begin
        case (mode_s)
          CNT_SAT: begin
            q_nxt_s = q_r;
          end
          CNT_ONESHOT: begin
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_DONE;
          end
          // Reserved encoding falls through to wrap behaviour.
          default: begin
            if (up) begin
              q_nxt_s = {N{1'b0}};
            end else begin
              q_nxt_s = max_val;
            end
            wrap_nxt_s = 1'b1;
          end
        endcase
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r     <= RESET_VAL;
      wrap_r  <= 1'b0;
      done_r  <= 1'b0;
      state_r <= ST_RUN;
    end else begin
      q_r     <= q_nxt_s;
      wrap_r  <= wrap_nxt_s;
      done_r  <= done_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign q    = q_r;
  assign wrap = wrap_r;
  assign done = done_r;
  assign tc   = en & (state_r == ST_RUN) & at_bound_s;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench for counter_updown_mod: directed scenarios plus a
// randomized run against a behavioural model.
module tb_counter_updown_mod;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] max_val;
  logic [1:0]   mode;
  logic [N-1:0] q;
  logic         tc;
  logic         wrap;
  logic         done;

  int checks = 0;
  int passed = 0;

  // Reference model state: count as a plain integer plus flags.
  longint m_q;
  bit     m_wrap;
  bit     m_done;

  always #5 clk = ~clk;

  counter_updown_mod #(.N(N), .RESET_VAL(32'd0)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .max_val(max_val), .mode(mode),
    .q(q), .tc(tc), .wrap(wrap), .done(done)
  );

  function automatic bit model_at_bound();
    if (up) return (m_q >= longint'(max_val));
    return (m_q == 0);
  endfunction

  function automatic bit model_tc();
    return en && !m_done && model_at_bound();
  endfunction

  // Advance the model with the inputs present at this edge, then clock the DUT.
  task automatic tick();
    if (reset) begin
      m_q = 0; m_wrap = 0; m_done = 0;
    end else if (load) begin
      m_q = longint'(load_val); m_wrap = 0; m_done = 0;
    end else if (en && !m_done) begin
      m_wrap = 0;
      if (!model_at_bound()) begin
        m_q = up ? m_q + 1 : m_q - 1;
      end else if (mode == 2'd1) begin
        m_q = m_q;
      end else if (mode == 2'd2) begin
        m_done = 1;
      end else begin
        m_q = up ? 0 : longint'(max_val);
        m_wrap = 1;
      end
    end else begin
      m_wrap = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 32'd0;
    max_val = 32'hFFFF_FFFF; mode = 2'd0;
    tick(); tick();
    checks++; if (q !== 32'd0) $display("FAIL reset_q q=%0d exp=0", q); else passed++;
    checks++; if (wrap !== 1'b0) $display("FAIL reset_wrap wrap=%0b exp=0", wrap); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done done=%0b exp=0", done); else passed++;
    checks++; if (tc !== 1'b0) $display("FAIL reset_tc tc=%0b exp=0", tc); else passed++;
    reset = 1'b0; en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (q !== i) $display("FAIL free_q step=%0d q=%0d exp=%0d", i, q, i); else passed++;
      checks++; if (wrap !== 1'b0) $display("FAIL free_wrap step=%0d wrap=%0b exp=0", i, wrap); else passed++;
    end
  endtask

  task automatic test_wrap();
    int eq_up[4] = '{4, 5, 0, 1};
    bit ew_up[4] = '{0, 0, 1, 0};
    bit et_up[4] = '{0, 1, 0, 0};
    int eq_dn[3] = '{0, 5, 4};
    bit ew_dn[3] = '{0, 1, 0};
    bit et_dn[3] = '{1, 0, 0};
    mode = 2'd0; max_val = 32'd5; en = 1'b0; load = 1'b1; load_val = 32'd3;
    tick();
    load = 1'b0;
    checks++; if (q !== 32'd3) $display("FAIL wrap_load q=%0d exp=3", q); else passed++;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (q !== eq_up[i]) $display("FAIL wrap_up_q i=%0d q=%0d exp=%0d", i, q, eq_up[i]); else passed++;
      checks++; if (wrap !== ew_up[i]) $display("FAIL wrap_up_pulse i=%0d wrap=%0b exp=%0b", i, wrap, ew_up[i]); else passed++;
      checks++; if (tc !== et_up[i]) $display("FAIL wrap_up_tc i=%0d tc=%0b exp=%0b", i, tc, et_up[i]); else passed++;
    end
    up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== eq_dn[i]) $display("FAIL wrap_dn_q i=%0d q=%0d exp=%0d", i, q, eq_dn[i]); else passed++;
      checks++; if (wrap !== ew_dn[i]) $display("FAIL wrap_dn_pulse i=%0d wrap=%0b exp=%0b", i, wrap, ew_dn[i]); else passed++;
      checks++; if (tc !== et_dn[i]) $display("FAIL wrap_dn_tc i=%0d tc=%0b exp=%0b", i, tc, et_dn[i]); else passed++;
    end
  endtask

  task automatic test_sat();
    int eq_up[6] = '{1, 2, 3, 3, 3, 3};
    bit et_up[6] = '{0, 0, 1, 1, 1, 1};
    int eq_dn[4] = '{2, 1, 0, 0};
    bit et_dn[4] = '{0, 0, 1, 1};
    mode = 2'd1; max_val = 32'd3; en = 1'b0; load = 1'b1; load_val = 32'd0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (q !== eq_up[i]) $display("FAIL sat_up_q i=%0d q=%0d exp=%0d", i, q, eq_up[i]); else passed++;
      checks++; if (tc !== et_up[i]) $display("FAIL sat_up_tc i=%0d tc=%0b exp=%0b", i, tc, et_up[i]); else passed++;
      checks++; if (wrap !== 1'b0) $display("FAIL sat_wrap i=%0d wrap=%0b exp=0", i, wrap); else passed++;
    end
    up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (q !== eq_dn[i]) $display("FAIL sat_dn_q i=%0d q=%0d exp=%0d", i, q, eq_dn[i]); else passed++;
      checks++; if (tc !== et_dn[i]) $display("FAIL sat_dn_tc i=%0d tc=%0b exp=%0b", i, tc, et_dn[i]); else passed++;
    end
  endtask

  task automatic test_oneshot();
    int eq[7] = '{1, 2, 3, 4, 4, 4, 4};
    bit ed[7] = '{0, 0, 0, 0, 1, 1, 1};
    bit et[7] = '{0, 0, 0, 1, 0, 0, 0};
    mode = 2'd2; max_val = 32'd4; en = 1'b0; load = 1'b1; load_val = 32'd0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (q !== eq[i]) $display("FAIL os_q i=%0d q=%0d exp=%0d", i, q, eq[i]); else passed++;
      checks++; if (done !== ed[i]) $display("FAIL os_done i=%0d done=%0b exp=%0b", i, done, ed[i]); else passed++;
      checks++; if (tc !== et[i]) $display("FAIL os_tc i=%0d tc=%0b exp=%0b", i, tc, et[i]); else passed++;
    end
    mode = 2'd0;
    tick();
    checks++; if (q !== 32'd4) $display("FAIL os_modechg_q q=%0d exp=4", q); else passed++;
    checks++; if (done !== 1'b1) $display("FAIL os_modechg_done done=%0b exp=1", done); else passed++;
    checks++; if (wrap !== 1'b0) $display("FAIL os_modechg_wrap wrap=%0b exp=0", wrap); else passed++;
    mode = 2'd2; load = 1'b1; load_val = 32'd2;
    tick();
    load = 1'b0;
    checks++; if (q !== 32'd2) $display("FAIL os_reload_q q=%0d exp=2", q); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL os_reload_done done=%0b exp=0", done); else passed++;
    tick();
    checks++; if (q !== 32'd3) $display("FAIL os_resume_q q=%0d exp=3", q); else passed++;
  endtask

  task automatic test_priority();
    mode = 2'd0; max_val = 32'd20; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 32'd7;
    tick();
    load = 1'b0;
    checks++; if (q !== 32'd7) $display("FAIL prio_load_q q=%0d exp=7", q); else passed++;
    mode = 2'd2; max_val = 32'd7;
    tick();
    checks++; if (done !== 1'b1) $display("FAIL prio_setup_done done=%0b exp=1", done); else passed++;
    reset = 1'b1; load = 1'b1; load_val = 32'd3;
    tick();
    reset = 1'b0; load = 1'b0;
    checks++; if (q !== 32'd0) $display("FAIL prio_reset_q q=%0d exp=0", q); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL prio_reset_done done=%0b exp=0", done); else passed++;
  endtask

  task automatic test_load_over_max();
    mode = 2'd0; max_val = 32'd5; up = 1'b1; en = 1'b0; load = 1'b1; load_val = 32'd9;
    tick();
    load = 1'b0;
    checks++; if (q !== 32'd9) $display("FAIL ovr_load_q q=%0d exp=9", q); else passed++;
    checks++; if (tc !== 1'b0) $display("FAIL ovr_tc_disabled tc=%0b exp=0", tc); else passed++;
    en = 1'b1; #1;
    checks++; if (tc !== 1'b1) $display("FAIL ovr_tc_enabled tc=%0b exp=1", tc); else passed++;
    tick();
    checks++; if (q !== 32'd0) $display("FAIL ovr_wrap_q q=%0d exp=0", q); else passed++;
    checks++; if (wrap !== 1'b1) $display("FAIL ovr_wrap_pulse wrap=%0b exp=1", wrap); else passed++;
    tick();
    checks++; if (q !== 32'd1) $display("FAIL ovr_next_q q=%0d exp=1", q); else passed++;
    en = 1'b0;
    tick(); tick();
    checks++; if (q !== 32'd1) $display("FAIL hold_q q=%0d exp=1", q); else passed++;
    checks++; if (tc !== 1'b0) $display("FAIL hold_tc tc=%0b exp=0", tc); else passed++;
    checks++; if (wrap !== 1'b0) $display("FAIL hold_wrap wrap=%0b exp=0", wrap); else passed++;
  endtask

  task automatic test_random();
    reset = 1'b1; load = 1'b0; en = 1'b0; max_val = 32'd5; mode = 2'd0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      load  = ($urandom_range(0, 11) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) load_val = $urandom_range(0, 9);
      else load_val = 32'hFFFF_FFFF - $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: max_val = 32'd0;
          1: max_val = 32'hFFFF_FFFF;
          2: max_val = 32'hFFFF_FFFE;
          default: max_val = $urandom_range(1, 8);
        endcase
      end
      #1;
      checks++; if (tc !== model_tc()) $display("FAIL rnd_tc i=%0d tc=%0b exp=%0b", i, tc, model_tc()); else passed++;
      tick();
      checks++; if (q !== m_q[31:0]) $display("FAIL rnd_q i=%0d q=%0h exp=%0h", i, q, m_q[31:0]); else passed++;
      checks++; if (wrap !== m_wrap) $display("FAIL rnd_wrap i=%0d wrap=%0b exp=%0b", i, wrap, m_wrap); else passed++;
      checks++; if (done !== m_done) $display("FAIL rnd_done i=%0d done=%0b exp=%0b", i, done, m_done); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_sat();
    test_oneshot();
    test_priority();
    test_load_over_max();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
